// File: rtl/crv32_dbg_loader_if.sv
// Debug memory port bundle between the program loader and the SoC debug port.
//   master : loader side; drives the request, address, enables and write data
//   slave  : memory side; returns dbg_ready and read data
interface crv32_dbg_loader_if;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic        dbg_ready;
  logic [31:0] dbg_di;

  modport master (output dbg_mem_op, dbg_wren, dbg_adr, dbg_do,
                  input  dbg_ready, dbg_di);
  modport slave  (input  dbg_mem_op, dbg_wren, dbg_adr, dbg_do,
                  output dbg_ready, dbg_di);
endinterface

// File: rtl/crv32_dbg_loader.sv
// Program loader. It holds the CPU in reset and receives a length-prefixed,
// little-endian byte image. It writes the image word by word through the
// debug memory port, optionally reads each word back, and checks a trailing
// 8-bit checksum. It releases the CPU only after a successful load.
//   clk, n_reset   : clock, async active-low reset
//   start          : one-cycle arm pulse (ignored while busy)
//   rx_data/valid  : incoming byte stream, one byte per strobe
//   dbg            : debug memory port (master side)
//   cpu_n_reset    : CPU reset, released only on DONE
//   busy/done/err  : status; done/err held until the next start
module crv32_dbg_loader #(
  parameter logic [31:0] BASE_ADR      = 32'h20000,
  parameter int          MAX_WORDS     = 1024,
  parameter bit          VERIFY        = 1'b1,
  parameter bit          HOLD_ON_RESET = 1'b1
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       start,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  crv32_dbg_loader_if.master         dbg,
  output logic                       cpu_n_reset,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_RDBK, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      st_q, st_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] len_q, len_d, word_q, word_d, adr_q, adr_d, cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic        op_q, op_d, cpu_q, cpu_d, busy_q, busy_d, done_q, done_d;
  logic [3:0]  wren_q, wren_d;
  logic [31:0] dadr_q, dadr_d, do_q, do_d;
  logic [1:0]  err_q, err_d;

  // Bytes arrive LSB first, so shifting in from the top leaves the word
  // little-endian after the 4th byte.
  logic [31:0] len_new, word_new, cnt_inc;
  logic        adv, fail;
  logic [1:0]  fail_code;

  assign len_new  = {rx_data, len_q[31:8]};
  assign word_new = {rx_data, word_q[31:8]};
  assign cnt_inc  = cnt_q + 32'd1;

  always_comb begin
    st_d = st_q; bcnt_d = bcnt_q; len_d = len_q; word_d = word_q;
    adr_d = adr_q; cnt_d = cnt_q; sum_d = sum_q;
    op_d = op_q; wren_d = wren_q; dadr_d = dadr_q; do_d = do_q;
    cpu_d = cpu_q; busy_d = busy_q; done_d = done_q; err_d = err_q;
    adv = 1'b0; fail = 1'b0; fail_code = 2'd0;

    case (st_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          st_d = S_LEN; cpu_d = 1'b0; busy_d = 1'b1;
          done_d = 1'b0; err_d = 2'd0; bcnt_d = 2'd0; sum_d = 8'd0;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          len_d  = len_new;
          sum_d  = sum_q + rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (len_new > 32'(MAX_WORDS)) begin
              fail = 1'b1; fail_code = 2'd1;
            end else if (len_new == 32'd0) begin
              st_d = S_CSUM;
            end else begin
              adr_d = BASE_ADR; cnt_d = 32'd0; st_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          word_d = word_new;
          sum_d  = sum_q + rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            st_d = S_WRITE; op_d = 1'b1; wren_d = 4'hF;
            dadr_d = adr_q; do_d = word_new;
          end
        end
      end
      S_WRITE: begin
        // No byte buffer: a byte arriving during an access is lost, so abort.
        if (rx_valid) begin
          fail = 1'b1; fail_code = 2'd2;
        end else if (dbg.dbg_ready) begin
          if (VERIFY) begin
            st_d = S_RDBK; wren_d = 4'h0;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_RDBK: begin
        if (rx_valid) begin
          fail = 1'b1; fail_code = 2'd2;
        end else if (dbg.dbg_ready) begin
          if (dbg.dbg_di != word_q) begin
            fail = 1'b1; fail_code = 2'd3;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == sum_q) begin
            st_d = S_DONE; done_d = 1'b1; cpu_d = 1'b1; busy_d = 1'b0;
          end else begin
            fail = 1'b1; fail_code = 2'd3;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase

    if (adv) begin
      op_d = 1'b0; wren_d = 4'h0;
      adr_d = adr_q + 32'd4;
      cnt_d = cnt_inc;
      st_d  = (cnt_inc == len_q) ? S_CSUM : S_DATA;
    end
    if (fail) begin
      st_d = S_ERR; err_d = fail_code; busy_d = 1'b0;
      op_d = 1'b0; wren_d = 4'h0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      st_q <= S_IDLE; bcnt_q <= 2'd0; len_q <= 32'd0; word_q <= 32'd0;
      adr_q <= 32'd0; cnt_q <= 32'd0; sum_q <= 8'd0;
      op_q <= 1'b0; wren_q <= 4'h0; dadr_q <= 32'd0; do_q <= 32'd0;
      cpu_q <= !HOLD_ON_RESET; busy_q <= 1'b0; done_q <= 1'b0; err_q <= 2'd0;
    end else begin
      st_q <= st_d; bcnt_q <= bcnt_d; len_q <= len_d; word_q <= word_d;
      adr_q <= adr_d; cnt_q <= cnt_d; sum_q <= sum_d;
      op_q <= op_d; wren_q <= wren_d; dadr_q <= dadr_d; do_q <= do_d;
      cpu_q <= cpu_d; busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
    end
  end

  assign dbg.dbg_mem_op = op_q;
  assign dbg.dbg_wren   = wren_q;
  assign dbg.dbg_adr    = dadr_q;
  assign dbg.dbg_do     = do_q;
  assign cpu_n_reset    = cpu_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_crv32_dbg_loader.sv
// Bench for crv32_dbg_loader: byte-stream driver, latency-programmable memory
// model and an access scoreboard (expected accesses are queued as each word is
// sent, and popped as the memory model completes each access).
module tb_crv32_dbg_loader;
  logic       clk = 1'b0, n_reset = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cpu_n_reset, busy, done;
  logic [1:0] err;

  crv32_dbg_loader_if bus();

  crv32_dbg_loader #(.BASE_ADR(32'h20000), .MAX_WORDS(4), .VERIFY(1'b1),
                     .HOLD_ON_RESET(1'b1)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .dbg(bus), .cpu_n_reset(cpu_n_reset),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [31:0] adr; logic [31:0] dat; } acc_t;
  acc_t exp_q[$];
  logic [31:0] mem [logic [31:0]];

  int nchk = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model + scoreboard ----------------
  int   lat = 2;
  bit   corrupt = 1'b0;
  int   wcnt = 0;
  bit   hold_v = 1'b0;
  logic [31:0] hold_adr;
  logic [3:0]  hold_wren;
  acc_t got;

  task automatic sb_pop(input acc_t g);
    acc_t e;
    if (exp_q.size() == 0) begin
      chk("extra_access", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("acc_wr", 32'(g.wr), 32'(e.wr));
      chk("acc_adr", g.adr, e.adr);
      if (e.wr) chk("acc_dat", g.dat, e.dat);
    end
  endtask

  initial begin
    bus.dbg_ready = 1'b0;
    bus.dbg_di    = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (bus.dbg_ready) begin
        bus.dbg_ready = 1'b0; wcnt = 0; hold_v = 1'b0;
        if (n_reset) sb_pop(got);
      end else if (bus.dbg_mem_op) begin
        if (hold_v) begin
          chk("adr_stable", bus.dbg_adr, hold_adr);
          chk("wren_stable", 32'(bus.dbg_wren), 32'(hold_wren));
        end
        hold_v = 1'b1; hold_adr = bus.dbg_adr; hold_wren = bus.dbg_wren;
        wcnt++;
        if (wcnt >= lat) begin
          bus.dbg_ready = 1'b1;
          got.wr  = (bus.dbg_wren == 4'hF);
          got.adr = bus.dbg_adr;
          got.dat = bus.dbg_do;
          if (got.wr) mem[got.adr] = bus.dbg_do;
          else bus.dbg_di = (mem.exists(got.adr) ? mem[got.adr] : 32'h0) ^
                            {31'b0, corrupt && got.adr == 32'h20004};
        end
      end else begin
        wcnt = 0; hold_v = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{wr: 1'b1, adr: a, dat: d});
    exp_q.push_back('{wr: 1'b0, adr: a, dat: 32'h0});
  endtask

  task automatic wait_bus();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.dbg_mem_op && exp_q.size() == 0) break;
    end
    chk("bus_done_in_time", 32'(i < 200), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_op"}, 32'(bus.dbg_mem_op), 32'd0);
    chk({tag, "_wren"}, 32'(bus.dbg_wren), 32'd0);
    chk({tag, "_adr"}, bus.dbg_adr, 32'd0);
    chk({tag, "_do"}, bus.dbg_do, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cpu"}, 32'(cpu_n_reset), 32'd0);
  endtask

  // Two-word image 0x6F, 0x01; optional start pulse in the middle of LEN.
  task automatic run_basic(input logic [7:0] cs, input bit poke);
    logic [7:0] sum_exp;
    bit ok;
    sum_exp = 8'h02 + 8'h6F + 8'h01;
    ok = (cs == sum_exp);
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cpu", 32'(cpu_n_reset), 32'd0);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_err_clr", 32'(err), 32'd0);
    send(8'h02); send(8'h00);
    if (poke) begin
      pulse_start();
      chk("poke_busy", 32'(busy), 32'd1);
    end
    send(8'h00); send(8'h00);
    push_word(32'h20000, 32'h6F); send_word(32'h6F); wait_bus();
    push_word(32'h20004, 32'h01); send_word(32'h01); wait_bus();
    chk("done_pre", 32'(done), 32'd0);
    send(cs);
    chk("fin_done", 32'(done), 32'(ok));
    chk("fin_cpu", 32'(cpu_n_reset), 32'(ok));
    chk("fin_err", 32'(err), ok ? 32'd0 : 32'd3);
    chk("fin_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // basic load, then checksum failure
    run_basic(8'h72, 1'b0);
    run_basic(8'h73, 1'b0);

    // verify mismatch on the second word
    corrupt = 1'b1;
    pulse_start();
    send_word(32'd2);
    push_word(32'h20000, 32'h6F); send_word(32'h6F); wait_bus();
    push_word(32'h20004, 32'h01); send_word(32'h01); wait_bus();
    chk("vfy_err", 32'(err), 32'd3);
    chk("vfy_cpu", 32'(cpu_n_reset), 32'd0);
    chk("vfy_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("vfy_quiet", 32'(bus.dbg_mem_op), 32'd0);
    corrupt = 1'b0;

    // length above MAX_WORDS
    pulse_start();
    send_word(32'd5);
    chk("len5_err", 32'(err), 32'd1);
    chk("len5_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("len5_no_acc", 32'(bus.dbg_mem_op), 32'd0);

    // empty image
    pulse_start();
    send_word(32'd0);
    chk("len0_busy", 32'(busy), 32'd1);
    send(8'h00);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_cpu", 32'(cpu_n_reset), 32'd1);
    chk("len0_err", 32'(err), 32'd0);

    // overrun while memory stalls
    lat = 20;
    pulse_start();
    send_word(32'd1);
    send_word(32'hAABBCCDD);
    repeat (3) @(negedge clk);
    chk("ovr_in_write", 32'(bus.dbg_mem_op), 32'd1);
    send(8'h55);
    chk("ovr_err", 32'(err), 32'd2);
    chk("ovr_mem_op", 32'(bus.dbg_mem_op), 32'd0);
    lat = 2;
    repeat (25) @(negedge clk);

    // reset mid-DATA, then restart with a start pulse while busy
    pulse_start();
    send_word(32'd1);
    send(8'hAA); send(8'hBB);
    @(negedge clk); n_reset = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk); n_reset = 1'b1;
    run_basic(8'h72, 1'b1);

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/crv32_dbg_loader.md
# crv32_dbg_loader

Synthesizable program loader that drives the SoC debug memory port (`dbg_mem_op`, `dbg_wren`, `dbg_adr`, `dbg_do`) from a byte stream, normally the UART RX path.
- Holds the CPU in reset, receives a length-prefixed image, and writes it word by word from a parameterised base address.
- Optionally reads each word back to verify it, then checks a trailing checksum.
- Releases `cpu_n_reset` only on success.
- It replaces hand-forced debug-port sequences with a real handshake, variable length, verify and error reporting.

## Interface
Parameters:
- `BASE_ADR`, 32'h20000, byte address of the first word written.
- `MAX_WORDS`, 1024, largest accepted image length in words.
- `VERIFY`, 1, 1 = read back and compare every word after writing it.
- `HOLD_ON_RESET`, 1, reset value of `cpu_n_reset`: 1 gives low (wait for image), 0 gives high.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `n_reset` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that arms the loader.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `dbg_ready` in 1: memory has completed the current debug access.
- `dbg_di` in 32: read data, valid when `dbg_ready` = 1 on a read.
- `dbg_mem_op` out 1: debug access request.
- `dbg_wren` out 4: byte write enables; 4'hF = write, 4'h0 = read.
- `dbg_adr` out 32: access byte address.
- `dbg_do` out 32: write data.
- `cpu_n_reset` out 1: CPU reset, active-low.
- `busy` out 1: loader is between IDLE and DONE/ERR.
- `done` out 1: load succeeded; held until the next `start`.
- `err` out 2: 0 none, 1 length > MAX_WORDS, 2 overrun, 3 verify/checksum mismatch; held until the next `start`.

## Operation
- States: IDLE, LEN, DATA, WRITE, RDBK, CSUM, DONE, ERR.
- IDLE: waits for `start`. On `start`:
  - drive `cpu_n_reset` = 0;
  - clear `done`, `err`, the byte counter and `sum`;
  - go to LEN.
- LEN: collects 4 bytes, little-endian, into `len`.
  - `len` > MAX_WORDS: go to ERR, err=1.
  - `len` = 0: go to CSUM.
  - otherwise: `adr` = BASE_ADR, go to DATA.
- DATA: assembles 4 bytes little-endian into `word`; after the 4th byte go to WRITE.
- WRITE: drives `dbg_mem_op` = 1, `dbg_wren` = 4'hF, `dbg_adr` = `adr`, `dbg_do` = `word`. These are stable until `dbg_ready` is sampled high. Then:
  - VERIFY = 1: go to RDBK;
  - VERIFY = 0: advance.
- RDBK: drives `dbg_mem_op` = 1, `dbg_wren` = 0, same `dbg_adr`. On `dbg_ready`, compare `dbg_di` with `word`:
  - mismatch: go to ERR, err=3;
  - match: advance.
- Advance:
  - `adr` += 4 (32-bit wrap);
  - `cnt` += 1;
  - if `cnt` = `len`, go to CSUM; otherwise go to DATA.
- CSUM: the next byte must equal `sum`, the 8-bit modular sum of every length and data byte.
  - equal: go to DONE;
  - not equal: go to ERR, err=3.
- DONE: `cpu_n_reset` = 1, `done` = 1.
- ERR: `cpu_n_reset` stays 0; `err` is held.
- DONE and ERR return to LEN on the next `start`.
- `rx_valid` in WRITE or RDBK is an overrun: go to ERR, err=2. There is no byte buffer.
- `start` while `busy` is ignored.
- `rx_valid` in IDLE, DONE or ERR is ignored.

## Timing
- Reset values:
  - state IDLE;
  - `dbg_mem_op` 0, `dbg_wren` 0, `dbg_adr` 0, `dbg_do` 0;
  - `busy` 0, `done` 0, `err` 0;
  - `cpu_n_reset` = !HOLD_ON_RESET.
- All outputs are registered.
- `busy` rises the cycle after `start`. `cpu_n_reset` falls in that same cycle.
- The first WRITE cycle is the cycle after the 4th data byte's `rx_valid`.
- `dbg_mem_op` drops in the cycle after `dbg_ready` is sampled. `dbg_ready` high in the first request cycle is accepted.
- Minimum per word: VERIFY = 0 takes 1 access cycle; VERIFY = 1 takes 2.
- `dbg_wren` and `dbg_adr` never change while `dbg_mem_op` = 1 and `dbg_ready` = 0.
- `done` and `cpu_n_reset` rise together, 1 cycle after the checksum byte.
- ERR is entered 1 cycle after the offending event. `dbg_mem_op` is 0 in ERR.
- `n_reset` asserted mid-transfer aborts immediately to the reset values; no partial write is completed.

## Test plan
- Basic load, VERIFY = 1, memory `dbg_ready` after 2 cycles.
  - Stimulus: bytes 02 00 00 00, 6F 00 00 00, 01 00 00 00, checksum 72.
  - Required: writes 0x0000006F at 0x20000 and 0x00000001 at 0x20004, each followed by a matching read; `done` = 1; `cpu_n_reset` rises; `err` = 0.
- Checksum failure: same image with checksum 73.
  - Required: both writes occur; `err` = 3; `cpu_n_reset` stays 0; `done` = 0.
- Verify mismatch: memory model corrupts bit 0 on readback of the word at 0x20004.
  - Required: ERR with `err` = 3 right after that read; no further access.
- Length limit and empty image, MAX_WORDS = 4.
  - Length 5: `err` = 1 after the 4th length byte, no debug access.
  - Length 0 with checksum 00: `done` = 1 with no access.
- Overrun: memory stalls `dbg_ready` for 20 cycles while `rx_valid` pulses during WRITE.
  - Required: `err` = 2; `dbg_mem_op` = 0 the next cycle.
- Reset and restart.
  - `n_reset` pulsed mid-DATA: all outputs return to reset values; `cpu_n_reset` = 0 with HOLD_ON_RESET = 1.
  - Subsequent `start` plus the basic image: load succeeds.
  - `start` while `busy`: ignored.
